vu_carry_adjust_pipe: RTL and testbench



---
 rtl/vu_carry_adjust_pipe.sv | 146 ++++++++++++++
 tb/tb_vu_carry_adjust_pipe.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vu_carry_adjust_pipe.sv
// Per-lane complemented carry-out of a+b+cin via a conditional-sum tree; latency PIPE (1 or 2) cycles.
// stall freezes every register (inputs that cycle are dropped); reset flushes all in-flight work.
module vu_carry_adjust_pipe #(
    parameter int WIDTH = 25,
    parameter int LANES = 8,
    parameter int PIPE  = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall,
    input  logic                     in_valid,
    input  logic [LANES*WIDTH-1:0]   a,
    input  logic [LANES*WIDTH-1:0]   b,
    input  logic [LANES-1:0]         cin_en,
    input  logic [LANES-1:0]         lane_en,
    input  logic [LANES-1:0]         csa_co,
    input  logic [LANES-1:0]         cpa_co,
    output logic                     out_valid,
    output logic [LANES-1:0]         co_l,
    output logic [LANES-1:0]         carry_fix
);

    localparam int L    = $clog2(WIDTH);
    localparam int M    = L / 2;
    localparam int HALF = (WIDTH + 1) / 2;

    // Applies tree ranks r_from+1 .. r_to. Index k holds group k of the current rank;
    // an unpaired top group passes straight through, so no padding is needed.
    function automatic logic [2*WIDTH-1:0] merge_ranks(
        input logic [WIDTH-1:0] g0_in,
        input logic [WIDTH-1:0] g1_in,
        input int               r_from,
        input int               r_to
    );
        logic [WIDTH-1:0] g0, g1, n0, n1;
        int               ng_prev;
        g0 = g0_in;
        g1 = g1_in;
        for (int r = 1; r <= L; r++) begin
            if (r > r_from && r <= r_to) begin
                ng_prev = (WIDTH + (1 << (r - 1)) - 1) >> (r - 1);
                n0 = '1;
                n1 = '1;
                for (int k = 0; k < HALF; k++) begin
                    if (2 * k + 1 < ng_prev) begin
                        n0[k] = g0[2*k] ? g0[2*k+1] : g1[2*k+1];
                        n1[k] = g1[2*k] ? g0[2*k+1] : g1[2*k+1];
                    end else if (2 * k < ng_prev) begin
                        n0[k] = g0[2*k];
                        n1[k] = g1[2*k];
                    end
                end
                g0 = n0;
                g1 = n1;
            end
        end
        return {g1, g0};
    endfunction

    logic [LANES-1:0][WIDTH-1:0] mid0_d, mid1_d;
    logic [LANES-1:0][WIDTH-1:0] s2_g0, s2_g1;
    logic                        s2_vld;
    logic [LANES-1:0]            s2_cin, s2_en;
    logic                        vld_d, vld_q;
    logic [LANES-1:0]            co_l_d, co_l_q;

    // Leaves: nand = complemented carry with cin 0, nor = complemented carry with cin 1.
    always_comb begin
        logic [2*WIDTH-1:0] g;
        g      = '0;
        mid0_d = '1;
        mid1_d = '1;
        for (int i = 0; i < LANES; i++) begin
            g = merge_ranks(~(a[i*WIDTH +: WIDTH] & b[i*WIDTH +: WIDTH]),
                            ~(a[i*WIDTH +: WIDTH] | b[i*WIDTH +: WIDTH]), 0, M);
            mid0_d[i] = g[WIDTH-1:0];
            mid1_d[i] = g[2*WIDTH-1:WIDTH];
        end
    end

    if (PIPE == 2) begin : g_mid
        logic                        vld_mid_d, vld_mid_q;
        logic [LANES-1:0]            cin_mid_d, cin_mid_q, en_mid_d, en_mid_q;
        logic [LANES-1:0][WIDTH-1:0] mid0_q, mid1_q;

        always_comb begin
            vld_mid_d = in_valid;
            cin_mid_d = cin_en;
            en_mid_d  = lane_en;
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                vld_mid_q <= 1'b0;
                cin_mid_q <= '0;
                en_mid_q  <= '0;
                mid0_q    <= '1;
                mid1_q    <= '1;
            end else if (!stall) begin
                vld_mid_q <= vld_mid_d;
                cin_mid_q <= cin_mid_d;
                en_mid_q  <= en_mid_d;
                mid0_q    <= mid0_d;
                mid1_q    <= mid1_d;
            end
        end

        assign s2_vld = vld_mid_q;
        assign s2_cin = cin_mid_q;
        assign s2_en  = en_mid_q;
        assign s2_g0  = mid0_q;
        assign s2_g1  = mid1_q;
    end else begin : g_nomid
        assign s2_vld = in_valid;
        assign s2_cin = cin_en;
        assign s2_en  = lane_en;
        assign s2_g0  = mid0_d;
        assign s2_g1  = mid1_d;
    end

    always_comb begin
        logic [2*WIDTH-1:0] f;
        f      = '0;
        vld_d  = s2_vld;
        co_l_d = '1;
        for (int i = 0; i < LANES; i++) begin
            f = merge_ranks(s2_g0[i], s2_g1[i], M, L);
            co_l_d[i] = s2_en[i] ? (s2_cin[i] ? f[WIDTH] : f[0]) : 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q  <= 1'b0;
            co_l_q <= '1;
        end else if (!stall) begin
            vld_q  <= vld_d;
            co_l_q <= co_l_d;
        end
    end

    assign out_valid = vld_q;
    assign co_l      = vld_q ? co_l_q : '1;
    assign carry_fix = {LANES{vld_q}} & (~(co_l ^ csa_co) ^ cpa_co);

endmodule

// File: tb/tb_vu_carry_adjust_pipe.sv
// Bench for vu_carry_adjust_pipe: directed checks on a PIPE=1 instance, randomized
// stall/valid traffic on a PIPE=2 WIDTH=17 LANES=4 instance against an arithmetic reference.
module tb_vu_carry_adjust_pipe;
    localparam int W1 = 25, N1 = 8, W2 = 17, N2 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst1, stall1, iv1, ov1;
    logic [N1*W1-1:0] a1, b1;
    logic [N1-1:0]    cin1, en1, csa1, cpa1, col1, cf1;

    logic             rst2, stall2, iv2, ov2;
    logic [N2*W2-1:0] a2, b2;
    logic [N2-1:0]    cin2, en2, csa2, cpa2, col2, cf2;

    vu_carry_adjust_pipe #(.WIDTH(W1), .LANES(N1), .PIPE(1)) dut1 (
        .clk(clk), .reset(rst1), .stall(stall1), .in_valid(iv1), .a(a1), .b(b1),
        .cin_en(cin1), .lane_en(en1), .csa_co(csa1), .cpa_co(cpa1),
        .out_valid(ov1), .co_l(col1), .carry_fix(cf1));

    vu_carry_adjust_pipe #(.WIDTH(W2), .LANES(N2), .PIPE(2)) dut2 (
        .clk(clk), .reset(rst2), .stall(stall2), .in_valid(iv2), .a(a2), .b(b2),
        .cin_en(cin2), .lane_en(en2), .csa_co(csa2), .cpa_co(cpa2),
        .out_valid(ov2), .co_l(col2), .carry_fix(cf2));

    typedef struct { logic v; logic [N2-1:0] c; } slot_t;
    slot_t           dl[$];
    logic [N2-1:0]   sb[$];
    int n_tests = 0, n_fail = 0, acc = 0, seen = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: lane carry = bit w of the plain integer sum; disabled lanes read 1.
    function automatic logic [7:0] exp_co(input int w, input int lanes, input logic [255:0] a,
                                          input logic [255:0] b, input logic [7:0] cin,
                                          input logic [7:0] en);
        logic [7:0]      r;
        longint unsigned ai, bi, s, m;
        r = '0;
        m = (64'd1 << w) - 64'd1;
        for (int i = 0; i < 8; i++) begin
            if (i < lanes) begin
                ai = 64'(a >> (i * w)) & m;
                bi = 64'(b >> (i * w)) & m;
                s  = ai + bi + 64'(cin[i]);
                r[i] = en[i] ? ~s[w] : 1'b1;
            end
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string tag, input logic v, input logic [N1-1:0] c);
        logic [N1-1:0] ec, ef;
        ec = v ? c : '1;
        ef = ~(ec ^ csa1) ^ cpa1;
        if (!v) ef = '0;
        chk({tag, "/vld"}, 64'(ov1), 64'(v));
        chk({tag, "/co_l"}, 64'(col1), 64'(ec));
        chk({tag, "/fix"}, 64'(cf1), 64'(ef));
    endtask

    task automatic rand1();
        for (int i = 0; i < N1; i++) begin
            case ($urandom_range(0, 2))
                0: begin a1[i*W1 +: W1] = W1'($urandom); b1[i*W1 +: W1] = W1'($urandom); end
                1: begin a1[i*W1 +: W1] = '1; b1[i*W1 +: W1] = W1'($urandom_range(0, 1)); end
                default: begin a1[i*W1 +: W1] = W1'($urandom); b1[i*W1 +: W1] = ~a1[i*W1 +: W1]; end
            endcase
        end
        cin1 = N1'($urandom);
        en1  = ($urandom_range(0, 3) == 0) ? N1'($urandom) : '1;
        csa1 = N1'($urandom);
        cpa1 = N1'($urandom);
    endtask

    task automatic rand2();
        for (int i = 0; i < N2; i++) begin
            case ($urandom_range(0, 2))
                0: begin a2[i*W2 +: W2] = W2'($urandom); b2[i*W2 +: W2] = W2'($urandom); end
                1: begin a2[i*W2 +: W2] = '1; b2[i*W2 +: W2] = W2'($urandom_range(0, 1)); end
                default: begin a2[i*W2 +: W2] = W2'($urandom); b2[i*W2 +: W2] = ~a2[i*W2 +: W2]; end
            endcase
        end
        cin2 = N2'($urandom);
        en2  = ($urandom_range(0, 3) == 0) ? N2'($urandom) : '1;
        csa2 = N2'($urandom);
        cpa2 = N2'($urandom);
    endtask

    function automatic logic [N2-1:0] cur_exp2();
        logic [7:0] e8;
        e8 = exp_co(W2, N2, 256'(a2), 256'(b2), 8'(cin2), 8'(en2));
        return e8[N2-1:0];
    endfunction

    // One clock of dut2: advance the reference delay line and scoreboard, then compare.
    task automatic step2(input string tag);
        logic [N2-1:0] e, ec, ef;
        slot_t         s;
        e = cur_exp2();
        tick();
        if (rst2) begin
            dl.delete();
            s.v = 1'b0;
            s.c = '1;
            repeat (2) dl.push_back(s);
            acc -= sb.size();
            sb.delete();
        end else if (!stall2) begin
            s.v = iv2;
            s.c = e;
            dl.push_back(s);
            void'(dl.pop_front());
            if (iv2) begin
                sb.push_back(e);
                acc++;
            end
        end
        s  = dl[0];
        ec = s.v ? s.c : '1;
        ef = ~(ec ^ csa2) ^ cpa2;
        if (!s.v) ef = '0;
        chk({tag, "/vld"}, 64'(ov2), 64'(s.v));
        chk({tag, "/co_l"}, 64'(col2), 64'(ec));
        chk({tag, "/fix"}, 64'(cf2), 64'(ef));
        if (!rst2 && !stall2 && ov2) begin
            chk({tag, "/sb_nonempty"}, 64'(sb.size() != 0), 64'(1));
            if (sb.size() != 0) begin
                chk({tag, "/order"}, 64'(col2), 64'(sb.pop_front()));
                seen++;
            end
        end
    endtask

    logic [N2-1:0] v0, v1;
    logic [N1-1:0] e1;
    logic [1:0]    tbl_in [4];
    logic          tbl_out [4];

    initial begin
        slot_t s0;
        rst1 = 1'b1; stall1 = 1'b0; iv1 = 1'b0; a1 = '0; b1 = '0;
        cin1 = '0; en1 = '1; csa1 = '0; cpa1 = '0;
        rst2 = 1'b1; stall2 = 1'b0; iv2 = 1'b0; a2 = '0; b2 = '0;
        cin2 = '0; en2 = '1; csa2 = '0; cpa2 = '0;
        s0.v = 1'b0;
        s0.c = '1;
        repeat (2) dl.push_back(s0);

        // Reset with stall and in_valid high: reset must win.
        stall1 = 1'b1; iv1 = 1'b1; rand1();
        tick(); check1("rst_a", 1'b0, '1);
        tick(); check1("rst_b", 1'b0, '1);
        rst1 = 1'b0; stall1 = 1'b0; iv1 = 1'b0;
        tick(); check1("post_rst", 1'b0, '1);

        // Full-length carry chains, all lanes enabled.
        a1 = '0; b1 = '0; en1 = '1; iv1 = 1'b1; cin1 = 8'b0000_1010;
        a1[0*W1 +: W1] = '1;
        a1[1*W1 +: W1] = '1;
        a1[2*W1 +: W1] = '1; b1[2*W1 +: W1] = 25'd1;
        a1[3*W1 +: W1] = '1; b1[3*W1 +: W1] = '1;
        tick(); check1("fullcarry", 1'b1, 8'hF1);

        // Correction truth table on lane 0 with co_l[0]=0, output held by stall.
        a1 = '0; b1 = '0; a1[0 +: W1] = '1; cin1 = 8'h01; en1 = '1;
        tick(); check1("fix_load", 1'b1, 8'hFE);
        stall1 = 1'b1;
        tbl_in[0] = 2'b10; tbl_out[0] = 1'b0;
        tbl_in[1] = 2'b00; tbl_out[1] = 1'b1;
        tbl_in[2] = 2'b01; tbl_out[2] = 1'b0;
        tbl_in[3] = 2'b11; tbl_out[3] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            csa1 = N1'($urandom); cpa1 = N1'($urandom);
            csa1[0] = tbl_in[k][1]; cpa1[0] = tbl_in[k][0];
            #1;
            check1("fix_tbl", 1'b1, 8'hFE);
            chk("fix_bit0", 64'(cf1[0]), 64'(tbl_out[k]));
        end
        tick(); check1("fix_held", 1'b1, 8'hFE);
        stall1 = 1'b0;

        // Lane enable masks generated carries.
        for (int i = 0; i < N1; i++) begin
            a1[i*W1 +: W1] = '1; b1[i*W1 +: W1] = 25'd1;
        end
        en1 = 8'h0F; cin1 = '0;
        tick(); check1("lane_en", 1'b1, 8'hF0);

        for (int k = 0; k < 150; k++) begin
            rand1(); iv1 = ($urandom_range(0, 3) != 0);
            e1 = exp_co(W1, N1, 256'(a1), 256'(b1), cin1, en1);
            tick(); check1("rnd1", iv1, e1);
        end

        // Mid-operation reset while stalled, then first result one cycle later.
        rst1 = 1'b1; stall1 = 1'b1; iv1 = 1'b1;
        tick(); check1("midrst1", 1'b0, '1);
        rst1 = 1'b0; stall1 = 1'b0; rand1(); en1 = '1;
        e1 = exp_co(W1, N1, 256'(a1), 256'(b1), cin1, en1);
        tick(); check1("after_midrst1", 1'b1, e1);
        iv1 = 1'b0;

        // PIPE=2 stall sequence: V0, V1, then 3 stalled cycles carrying V2.
        rst2 = 1'b0; stall2 = 1'b0; iv2 = 1'b0;
        step2("idle2");
        rand2(); en2 = '1; iv2 = 1'b1; v0 = cur_exp2();
        step2("v0");
        chk("stall/v0_latency", 64'(ov2), 64'(0));
        rand2(); en2 = '1; v1 = cur_exp2();
        step2("v1");
        chk("stall/v0_out", 64'(col2), 64'(v0));
        stall2 = 1'b1; rand2(); en2 = '1;
        repeat (3) begin
            step2("stall");
            chk("stall/hold_vld", 64'(ov2), 64'(1));
            chk("stall/hold_v0", 64'(col2), 64'(v0));
        end
        stall2 = 1'b0; iv2 = 1'b0;
        step2("release");
        chk("stall/v1_out", 64'(col2), 64'(v1));
        step2("release2");
        chk("stall/v2_absent", 64'(ov2), 64'(0));

        for (int k = 0; k < 1000; k++) begin
            rand2();
            rst2   = (k == 500 || k == 501);
            stall2 = ($urandom_range(0, 3) == 0);
            iv2    = ($urandom_range(0, 4) != 0);
            step2("rnd2");
        end
        rst2 = 1'b0; stall2 = 1'b0; iv2 = 1'b0;
        repeat (3) step2("drain");
        chk("count/accepted_vs_seen", 64'(seen), 64'(acc));
        chk("count/sb_empty", 64'(sb.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
